// File: rtl/training_sequencer.sv
// Training-set store and epoch sequencer that feeds a perceptron one sample at a time.
// Each sample gets a present cycle and an evaluate cycle. Training ends on an error-free epoch or at MAX_EPOCHS.
module training_sequencer #(
  parameter int DEPTH      = 8,
  parameter int MAX_EPOCHS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_in1,
  input  logic [3:0] wr_in2,
  input  logic [6:0] wr_in3,
  input  logic       wr_label,
  input  logic [3:0] num_samples,
  input  logic       start,
  input  logic       p_out,
  output logic [3:0] p_in1,
  output logic [3:0] p_in2,
  output logic [6:0] p_in3,
  output logic       p_desired,
  output logic       busy,
  output logic       done,
  output logic       converged,
  output logic [7:0] epoch_count,
  output logic [3:0] err_count
);

  typedef struct packed {
    logic [3:0] in1;
    logic [3:0] in2;
    logic [6:0] in3;
    logic       label;
  } sample_t;

  typedef enum logic [2:0] {
    IDLE,
    PRESENT,
    EVAL,
    EPOCH_END,
    DONE
  } state_t;

  state_t     state;
  sample_t    mem [DEPTH];
  sample_t    cur;
  sample_t    wr_sample;
  sample_t    first_sample;
  sample_t    next_sample;
  logic [3:0] n_lat;
  logic [2:0] idx;
  logic [2:0] idx_inc;
  logic [3:0] err;
  logic [7:0] epoch_nxt;
  logic       idle_like;
  logic       wr_accept;
  logic       start_ok;

  assign wr_sample = {wr_in1, wr_in2, wr_in3, wr_label};
  assign idle_like = (state == IDLE) || (state == DONE);
  assign wr_accept = wr_en && idle_like;
  assign start_ok  = start && idle_like && (num_samples != 4'd0) && (num_samples <= 4'(DEPTH));
  assign idx_inc   = idx + 3'd1;
  assign epoch_nxt = epoch_count + 8'd1;

  assign p_in1 = cur.in1;
  assign p_in2 = cur.in2;
  assign p_in3 = cur.in3;

  // Outside EVAL the perceptron sees its own output as the target, so it never updates.
  assign p_desired = (state == EVAL) ? cur.label : p_out;

  // NOTE: the store is built from flops and cleared by reset because a
  // reset must wipe the training set; a RAM macro could not do that.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_accept) begin
      mem[wr_addr] <= wr_sample;
    end
  end

  // NOTE: every output of combinational logic gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    first_sample = mem[0];
    if (wr_accept && (wr_addr == 3'd0)) first_sample = wr_sample;
    next_sample = mem[idx_inc];
  end

  // NOTE: state and outputs update with non-blocking assignments, so every
  // branch reads the pre-edge values of err, idx and epoch_count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur         <= '0;
      n_lat       <= '0;
      idx         <= '0;
      err         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      epoch_count <= '0;
      err_count   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            n_lat       <= num_samples;
            idx         <= '0;
            err         <= '0;
            epoch_count <= '0;
            done        <= 1'b0;
            converged   <= 1'b0;
            busy        <= 1'b1;
            cur         <= first_sample;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          state <= EVAL;
        end
        EVAL: begin
          if ((p_out != cur.label) && (err != 4'd15)) err <= err + 4'd1;
          if ({1'b0, idx} == (n_lat - 4'd1)) begin
            cur   <= '0;
            state <= EPOCH_END;
          end else begin
            idx   <= idx_inc;
            cur   <= next_sample;
            state <= PRESENT;
          end
        end
        EPOCH_END: begin
          err_count   <= err;
          epoch_count <= epoch_nxt;
          if (err == 4'd0) begin
            converged <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else if (epoch_nxt == 8'(MAX_EPOCHS)) begin
            converged <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            err   <= '0;
            idx   <= '0;
            cur   <= mem[0];
            state <= PRESENT;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_training_sequencer.sv
// Scoreboard bench for training_sequencer: random training runs against an epoch-level model,
// plus a run against a behavioural perceptron.
module tb_training_sequencer;

  localparam int DEPTH = 8;
  localparam int MAX_E = 3;
  localparam int MAX_B = 50;

  typedef struct packed {
    logic [3:0] in1;
    logic [3:0] in2;
    logic [6:0] in3;
    logic       label;
  } smp_t;

  typedef struct {
    int         cyc;
    logic [3:0] i1;
    logic [3:0] i2;
    logic [6:0] i3;
    logic       des;
    logic       busy;
    logic       done;
    logic       conv;
  } cyc_exp_t;

  typedef struct {
    int         cyc;
    logic       conv;
    logic [7:0] ep;
    logic [3:0] er;
  } res_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en = 0, wr_label = 0, start = 0, p_out = 0;
  logic [2:0] wr_addr = 0;
  logic [3:0] wr_in1 = 0, wr_in2 = 0, num_samples = 0;
  logic [6:0] wr_in3 = 0;
  logic [3:0] p_in1, p_in2, err_count;
  logic [6:0] p_in3;
  logic       p_desired, busy, done, converged;
  logic [7:0] epoch_count;

  logic       b_wr_en = 0, b_wr_label = 0, b_start = 0, b_pout;
  logic [2:0] b_wr_addr = 0;
  logic [3:0] b_wr_in1 = 0, b_wr_in2 = 0, b_num = 0;
  logic [6:0] b_wr_in3 = 0;
  logic [3:0] b_in1, b_in2, b_err_count;
  logic [6:0] b_in3;
  logic       b_desired, b_busy, b_done, b_converged;
  logic [7:0] b_epoch_count;

  training_sequencer #(.DEPTH(DEPTH), .MAX_EPOCHS(MAX_E)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_in1(wr_in1),
    .wr_in2(wr_in2), .wr_in3(wr_in3), .wr_label(wr_label), .num_samples(num_samples),
    .start(start), .p_out(p_out), .p_in1(p_in1), .p_in2(p_in2), .p_in3(p_in3),
    .p_desired(p_desired), .busy(busy), .done(done), .converged(converged),
    .epoch_count(epoch_count), .err_count(err_count)
  );

  training_sequencer #(.DEPTH(DEPTH), .MAX_EPOCHS(MAX_B)) dut_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_in1(b_wr_in1),
    .wr_in2(b_wr_in2), .wr_in3(b_wr_in3), .wr_label(b_wr_label), .num_samples(b_num),
    .start(b_start), .p_out(b_pout), .p_in1(b_in1), .p_in2(b_in2), .p_in3(b_in3),
    .p_desired(b_desired), .busy(b_busy), .done(b_done), .converged(b_converged),
    .epoch_count(b_epoch_count), .err_count(b_err_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  smp_t mm [DEPTH];
  cyc_exp_t cq [$];
  res_exp_t rq [$];
  logic done_q = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: per-cycle expectations keyed by cycle number, run results on the rising edge of done.
  always @(negedge clk) begin
    cyc_exp_t e;
    res_exp_t r;
    if (cq.size() > 0 && cq[0].cyc == cyc) begin
      e = cq.pop_front();
      check($sformatf("cycle_%0d", e.cyc),
            {p_in1, p_in2, p_in3, p_desired, busy, done, converged},
            {e.i1, e.i2, e.i3, e.des, e.busy, e.done, e.conv});
    end
    if (done && !done_q) begin
      if (rq.size() > 0) begin
        r = rq.pop_front();
        check("done_cycle", cyc, r.cyc);
        check("converged", converged, r.conv);
        check("epoch_count", epoch_count, r.ep);
        check("err_count", err_count, r.er);
      end else begin
        check("unexpected_done", done, 1'b0);
      end
    end
    done_q <= done;
  end

  // Behavioural perceptron for the second instance, plus a count of weight updates outside EVAL.
  int w1, w2, w3, wb, upd_cnt, mask_viol, b_t, b_n;
  logic b_run = 1'b0;

  function automatic bit is_eval(input int t, input int n);
    int c;
    if (t < 1) return 1'b0;
    c = (t - 1) % (2 * n + 1);
    return (c % 2 == 1) && (c < 2 * n);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      w1 <= 0; w2 <= 0; w3 <= 0; wb <= 0;
      upd_cnt <= 0; mask_viol <= 0; b_t <= 0;
      b_pout <= 1'b0;
    end else begin
      if (b_run) b_t <= b_t + 1;
      if (b_desired != b_pout) begin
        w1 <= w1 + (b_desired ? int'(b_in1) : -int'(b_in1));
        w2 <= w2 + (b_desired ? int'(b_in2) : -int'(b_in2));
        w3 <= w3 + (b_desired ? int'(b_in3) : -int'(b_in3));
        wb <= wb + (b_desired ? 1 : -1);
        upd_cnt <= upd_cnt + 1;
        if (!is_eval(b_t, b_n)) mask_viol <= mask_viol + 1;
      end
      b_pout <= (w1 * int'(b_in1) + w2 * int'(b_in2) + w3 * int'(b_in3) + wb) > 0;
    end
  end

  task automatic drive_wr(input smp_t s);
    wr_in1 = s.in1; wr_in2 = s.in2; wr_in3 = s.in3; wr_label = s.label;
  endtask

  task automatic wr(input int a, input smp_t s);
    @(posedge clk); #1;
    wr_en = 1; wr_addr = 3'(a); drive_wr(s);
    @(posedge clk); #1;
    wr_en = 0;
    mm[a] = s;
  endtask

  task automatic bad_start(input logic [3:0] n, input logic exp_done);
    @(posedge clk); #1;
    num_samples = n; start = 1;
    @(posedge clk); #1;
    start = 0;
    check($sformatf("bad_start_%0d_busy", n), busy, 1'b0);
    @(posedge clk); #1;
    check($sformatf("bad_start_%0d_done", n), {busy, done}, {1'b0, exp_done});
  endtask

  task automatic do_abort();
    #1 reset = 0;
    cq.delete();
    rq.delete();
    #1;
    check("reset_outputs", {p_in1, p_in2, p_in3, busy, done, converged, epoch_count, err_count}, '0);
    check("reset_desired_a", p_desired, p_out);
    p_out = ~p_out;
    #1;
    check("reset_desired_b", p_desired, p_out);
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
  endtask

  // One training run: the model derives epochs, errors and timing from per-sample responses.
  task automatic run(input int n, input int mode, input bit wr_same, input bit busy_wr,
                     input bit busy_st, input bit abort);
    logic resp [MAX_E][DEPTH];
    int errs [MAX_E];
    int e_fin, total, k, t_wr, t_st, t_ab, busy_cnt, c, ep;
    logic conv;
    logic po [];
    smp_t s;
    cyc_exp_t ce;
    @(posedge clk); #1;
    if (wr_same) begin
      s = smp_t'($urandom);
      wr_en = 1; wr_addr = 3'd0; drive_wr(s);
      mm[0] = s;
    end
    num_samples = 4'(n); start = 1;
    k = cyc + 1;
    for (int e = 0; e < MAX_E; e++) begin
      errs[e] = 0;
      for (int i = 0; i < n; i++) begin
        case (mode)
          0: resp[e][i] = mm[i].label;
          1: resp[e][i] = 1'b0;
          2: resp[e][i] = ($urandom_range(0, 3) == 0) ? ~mm[i].label : mm[i].label;
          default: resp[e][i] = 1'($urandom);
        endcase
        if (resp[e][i] != mm[i].label) errs[e]++;
      end
    end
    e_fin = MAX_E; conv = 0;
    for (int e = 0; e < MAX_E; e++) begin
      if (errs[e] == 0) begin e_fin = e + 1; conv = 1; break; end
    end
    total = e_fin * (2 * n + 1);
    po = new[total + 2];
    for (int t = 1; t <= total + 1; t++) begin
      po[t] = 1'($urandom);
      c = (t - 1) % (2 * n + 1);
      ep = (t - 1) / (2 * n + 1);
      ce = '{cyc: k + t - 1, i1: 0, i2: 0, i3: 0, des: po[t], busy: 1, done: 0, conv: 0};
      if (t <= total && c < 2 * n) begin
        s = mm[c / 2];
        ce.i1 = s.in1; ce.i2 = s.in2; ce.i3 = s.in3;
        if (c % 2 == 1) begin
          po[t] = resp[ep][c / 2];
          ce.des = s.label;
        end else begin
          ce.des = po[t];
        end
      end else if (t > total) begin
        ce.busy = 0; ce.done = 1; ce.conv = conv;
      end
      cq.push_back(ce);
    end
    rq.push_back('{cyc: k + total, conv: conv, ep: 8'(e_fin), er: 4'(errs[e_fin - 1])});
    t_wr = busy_wr ? $urandom_range(1, total) : 0;
    t_st = busy_st ? $urandom_range(1, total) : 0;
    t_ab = abort ? 2 * $urandom_range(1, n) : 0;
    @(posedge clk); #1;
    busy_cnt = 0;
    for (int t = 1; t <= total + 1; t++) begin
      wr_en = 0; start = 0;
      p_out = po[t];
      busy_cnt += int'(busy);
      if (t == t_wr) begin
        wr_en = 1; wr_addr = 3'($urandom); drive_wr(smp_t'($urandom));
      end
      if (t == t_st) begin
        start = 1; num_samples = 4'($urandom_range(1, DEPTH));
      end
      if (t == t_ab) begin
        do_abort();
        return;
      end
      @(posedge clk); #1;
    end
    wr_en = 0; start = 0;
    check($sformatf("busy_cycles_n%0d", n), busy_cnt, total);
    check("scoreboard_drained", cq.size() + rq.size(), 0);
  endtask

  task automatic integration();
    smp_t set [3];
    int waited;
    set[0] = '{4'd15, 4'd15, 7'd127, 1'b1};
    set[1] = '{4'd0, 4'd0, 7'd0, 1'b0};
    set[2] = '{4'd1, 4'd0, 7'd0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      b_wr_en = 1; b_wr_addr = 3'(i);
      b_wr_in1 = set[i].in1; b_wr_in2 = set[i].in2; b_wr_in3 = set[i].in3; b_wr_label = set[i].label;
    end
    @(posedge clk); #1;
    b_wr_en = 0; b_n = 3; b_num = 4'd3; b_start = 1; b_run = 1;
    @(posedge clk); #1;
    b_start = 0;
    waited = 0;
    while (!b_done && waited < MAX_B * 7 + 10) begin
      @(posedge clk); #1;
      waited++;
    end
    check("int_done", b_done, 1'b1);
    check("int_converged", b_converged, 1'b1);
    check("int_err_count", b_err_count, 4'd0);
    check("int_epochs_in_range", (b_epoch_count >= 8'd2) && (b_epoch_count <= 8'(MAX_B)), 1'b1);
    check("int_updates_only_in_eval", mask_viol, 0);
    check("int_weights_moved", upd_cnt > 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {p_in1, p_in2, p_in3, busy, done, converged, epoch_count, err_count}, '0);
    p_out = 1; #1;
    check("reset_desired_hi", p_desired, 1'b1);
    p_out = 0; #1;
    check("reset_desired_lo", p_desired, 1'b0);
    @(negedge clk) reset = 1;

    bad_start(4'd0, 1'b0);
    bad_start(4'd9, 1'b0);

    for (int i = 0; i < 4; i++) wr(i, smp_t'($urandom));
    run(4, 0, 0, 1, 1, 0);

    wr(0, smp_t'({12'($urandom), 4'b0001} | 16'h0001));
    wr(1, smp_t'({12'($urandom), 4'b0000} & 16'hFFFE));
    wr(2, smp_t'({12'($urandom), 4'b0001} | 16'h0001));
    run(3, 1, 0, 0, 0, 0);
    bad_start(4'd0, 1'b1);

    for (int i = 0; i < DEPTH; i++) wr(i, smp_t'($urandom));
    repeat (8) run($urandom_range(1, DEPTH), $urandom_range(2, 3), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    run(DEPTH, 0, 1, 1, 0, 0);

    run(5, 3, 0, 0, 0, 1);
    run(DEPTH, 2, 0, 0, 0, 0);

    integration();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/training_sequencer.md
# training_sequencer

Upstream driver for the `perceptron` stage. It stores a small labelled training set and plays it to the perceptron one sample at a time, epoch after epoch. Each sample is held for a present cycle and an evaluate cycle, and weight updates are masked outside the evaluate cycle. It counts misclassifications per epoch and stops when an epoch is error-free (converged) or after `MAX_EPOCHS` epochs.

## Interface
- `DEPTH`, 8: training-set storage depth (samples); address width 3.
- `MAX_EPOCHS`, 100: epoch limit (1..255).

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `wr_en`  in  1  write sample `wr_addr`; ignored while `busy`.
- `wr_addr`  in  3  sample slot.
- `wr_in1`  in  4  sample feature 1.
- `wr_in2`  in  4  sample feature 2.
- `wr_in3`  in  7  sample feature 3.
- `wr_label`  in  1  sample desired class.
- `num_samples`  in  4  active set size, sampled at `start`; legal range 1..DEPTH.
- `start`  in  1  begin training; ignored while `busy`.
- `p_out`  in  1  perceptron registered output.
- `p_in1`  out  4  to perceptron `in1`.
- `p_in2`  out  4  to perceptron `in2`.
- `p_in3`  out  7  to perceptron `in3`.
- `p_desired`  out  1  to perceptron `desired_out`.
- `busy`  out  1  training in progress.
- `done`  out  1  training finished; held until next accepted `start`.
- `converged`  out  1  valid with `done`; 1 means the last epoch had 0 errors.
- `epoch_count`  out  8  completed epochs.
- `err_count`  out  4  errors in the last completed epoch.

## Operation
- Storage: DEPTH × 16-bit entries (`in1`, `in2`, `in3`, `label`). All entries clear to 0 on reset.
- FSM states: `IDLE`, `PRESENT`, `EVAL`, `EPOCH_END`, `DONE`.
- **IDLE / DONE**
  - On `start` with `num_samples` in 1..DEPTH: latch N, set idx=0, err=0, `epoch_count`=0; clear `done` and `converged`; go to `PRESENT`.
  - `start` with N=0 or N>DEPTH is ignored.
- **PRESENT**: drive sample[idx] on `p_in*`, then go to `EVAL`.
- **EVAL**
  - Drive the same sample, with `p_desired` = label[idx].
  - If `p_out` != label, increment err (saturating at 15).
  - If idx==N-1, go to `EPOCH_END`; otherwise idx++ and go to `PRESENT`.
- **EPOCH_END**
  - Drive `p_in*` = 0; set `err_count` = err and `epoch_count` += 1.
  - If err==0: go to `DONE` with `converged`=1.
  - Else if the new `epoch_count`==MAX_EPOCHS: go to `DONE` with `converged`=0.
  - Otherwise: err=0, idx=0, go to `PRESENT`.
- **Update masking**: in every state except `EVAL`, `p_desired` = `p_out` (combinational from the perceptron's register, so there is no loop). This stops the perceptron from updating weights against a stale `out`.
- In `IDLE` and `DONE`, `p_in*` = 0.
- `busy` = 1 in `PRESENT`, `EVAL` and `EPOCH_END`.
- Write port: synchronous; a write takes effect at the clock edge. `wr_en` and `start` in the same cycle: the write completes, then training starts (the new sample is used).
- Widths: `err_count` is 4 bits (max 8 with DEPTH 8). idx compares against N-1 in 4 bits.

## Timing
- Reset (asynchronous assert, synchronous-safe release) gives:
  - state=`IDLE`
  - `p_in*`=0, `busy`=0, `done`=0, `converged`=0, `epoch_count`=0, `err_count`=0
  - `p_desired`=`p_out`
- `start` sampled at edge k puts the FSM in `PRESENT` during cycle k+1.
- An epoch takes 2N+1 cycles.
- Convergence in epoch 1: `done`=1 in cycle k+2N+2.
- Perceptron alignment:
  - `p_in*` are registered FSM outputs.
  - The perceptron registers `out` at the end of `PRESENT`.
  - During `EVAL`, `p_out` reflects the current sample. The perceptron compares it with the label at the end of `EVAL` and updates once per sample at most.
- Reset asserted mid-training: immediate return to `IDLE` and clear storage. Partial epoch results are discarded.

## Test plan
- **Reset**: assert reset mid-`EVAL` with a random `p_out` -> all outputs 0, `p_desired` tracks `p_out`, storage reads back 0 after the next run.
- **Single-epoch convergence**: load 4 samples; bench model drives `p_out` = label in `EVAL` -> `done`=1 and `converged`=1 exactly 10 cycles after the `start` edge, `epoch_count`=1, `err_count`=0.
- **Non-convergence**: MAX_EPOCHS=3, N=3, labels 1,0,1, `p_out` stuck at 0 -> `done`=1, `converged`=0, `epoch_count`=3, `err_count`=2, `busy` high for 21 cycles.
- **Ignored commands**:
  - `start` with N=0 or N=9 -> stays `IDLE`.
  - `wr_en` while `busy` -> slot unchanged, checked on the next run.
  - `start` during `busy` -> no restart.
- **Masking**: in `PRESENT` and `EPOCH_END`, force `p_out` to toggle -> `p_desired` equals `p_out` in every such cycle and equals the label only in `EVAL`.
- **Integration with `perceptron`**: load AND-like separable set (e.g. (15,15,127)->1, (0,0,0)->0, (1,0,0)->0), MAX_EPOCHS=50 -> `converged`=1; perceptron weights change only at `EVAL` edges.
